imem_rom: RTL

Parametrised instruction memory for the single-cycle/multi-cycle MIPS core. It replaces the fixed 32-word combinational instruction table with a synchronous-read, run-time-loadable store of DEPTH words, and adds a one-cycle fetch handshake, out-of-range and misalignment flags, and a program-load mode driven by the boot/debug loader. It sits between the PC register and the instruction decoder.

---
 rtl/imem_pkg.sv | 33 +++
 rtl/imem_rom_if.sv | 33 +++
 rtl/imem_array.sv | 37 +++
 rtl/imem_rom.sv | 96 +++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory.
// IMEM_PARITY_EN widens each stored word with an even-parity bit.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PROG   = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_INSTR = 32'h0800_0000;
    localparam logic [31:0] NOP           = 32'h0000_0000;

`ifdef IMEM_PARITY_EN
    localparam int ARR_W = 33;
`else
    localparam int ARR_W = 32;
`endif

    function automatic logic parity(input logic [31:0] d);
        return ^d;
    endfunction

    // Word as stored in the array: parity bit (when enabled) on top of the data.
    function automatic logic [ARR_W-1:0] arr_word(input logic [31:0] d);
`ifdef IMEM_PARITY_EN
        return {parity(d), d};
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/imem_rom_if.sv
// Fetch and program-load port bundle between core/loader (master) and imem_rom (slave).
interface imem_rom_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic          fetch_req;
    logic [30:0]   fetch_addr;
    logic          fetch_ready;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          fetch_oob;
    logic          fetch_misalign;
    logic          parity_err;
    logic          prog_en;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          prog_busy;

    modport master (
        output fetch_req, fetch_addr, prog_en, prog_we, prog_addr, prog_data,
        input  fetch_ready, instr_valid, instr, fetch_oob, fetch_misalign,
               parity_err, prog_busy
    );

    modport slave (
        input  fetch_req, fetch_addr, prog_en, prog_we, prog_addr, prog_data,
        output fetch_ready, instr_valid, instr, fetch_oob, fetch_misalign,
               parity_err, prog_busy
    );

endinterface

// File: rtl/imem_array.sv
// DEPTH-word storage with one synchronous write port and one enabled synchronous read port.
// Word width follows imem_pkg::ARR_W (33 bits under IMEM_PARITY_EN).
module imem_array
    import imem_pkg::*;
#(
    parameter int              DEPTH = 256,
    parameter int              W     = ARR_W,
    parameter logic [W-1:0]    INIT  = '0,
    localparam int             AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Power-up image; reset never touches the contents.
    logic [W-1:0] mem [DEPTH] = '{default: INIT};

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read register holds its value between accepted fetches.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_rom.sv
// Run-time loadable instruction memory: RUN/PROG/RESUME loader FSM, fetch decode, result flags.
// IMEM_PARITY_EN enables per-word parity checking on fetch.
module imem_rom #(
    parameter int          DEPTH         = 256,
    parameter logic [31:0] DEFAULT_INSTR = imem_pkg::DEFAULT_INSTR
) (
    input  logic      clk,
    input  logic      reset,
    imem_rom_if.slave bus
);
    import imem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t         state;
    logic           busy_q;
    logic           vld_q;
    logic           oob_q;
    logic           mis_q;
    logic           accept;
    logic           wr_en;
    logic           oob_c;
    logic           mis_c;
    logic [AW-1:0]  rd_idx;
    logic [ARR_W-1:0] rd_data;

    assign rd_idx = bus.fetch_addr[2 +: AW];
    assign oob_c  = |bus.fetch_addr[30:2+AW];
    assign mis_c  = |bus.fetch_addr[1:0];

    assign bus.fetch_ready = (state == RUN) && !bus.prog_en && !reset;
    assign accept          = bus.fetch_req && bus.fetch_ready;
    assign wr_en           = (state == PROG) && bus.prog_we && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
            oob_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            vld_q <= accept;
            if (accept) begin
                oob_q <= oob_c;
                mis_q <= mis_c;
            end
            case (state)
                RUN: if (bus.prog_en) begin
                    state  <= PROG;
                    busy_q <= 1'b1;
                end
                PROG: if (!bus.prog_en)
                    state <= RESUME;
                RESUME: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Bad-address fetches skip the array so rd_data keeps the last good word.
    imem_array #(
        .DEPTH (DEPTH),
        .W     (ARR_W),
        .INIT  (arr_word(DEFAULT_INSTR))
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (bus.prog_addr),
        .wdata (arr_word(bus.prog_data)),
        .re    (accept && !oob_c && !mis_c),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign bus.prog_busy      = busy_q;
    assign bus.instr_valid    = vld_q;
    assign bus.fetch_oob      = vld_q & oob_q;
    assign bus.fetch_misalign = vld_q & mis_q;
    assign bus.instr          = (oob_q | mis_q) ? DEFAULT_INSTR : rd_data[31:0];

`ifdef IMEM_PARITY_EN
    // Even parity over data+parity bit: any odd count means a flipped bit.
    assign bus.parity_err = vld_q & ~(oob_q | mis_q) & (^rd_data);
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
